// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register file's single write port between in-order pipeline
// writeback (always wins) and out-of-order long-unit (mul/div) results.
// Long-unit results wait in a small FIFO and drain into idle write slots.
// Queued results overwritten by a younger pipeline write are marked dead
// and later popped without writing. A stall request is raised when the
// FIFO has been waiting too long for a free slot.

module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic [4:0]  query_addr,
    output logic        query_busy,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);

    // FIFO storage: live flag, destination register, result
    logic        fifoLive [DEPTH];
    logic [4:0]  fifoAddr [DEPTH];
    logic [31:0] fifoData [DEPTH];

    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [SCNT_W-1:0] starveCnt;
    logic [SCNT_W-1:0] starveNext;

    logic pipeWrite;
    logic fifoEmpty;
    logic fifoFull;
    logic doPush;
    logic doPop;
    logic pushLive;
    logic busyAny;

    logic [PTR_W-1:0] slotOffset [DEPTH];
    logic             slotUsed   [DEPTH];

    // Write-slot arbitration and FIFO handshake decode
    always_comb begin
        pipeWrite = pipe_we && (pipe_waddr != 5'd0);
        fifoEmpty = (count == '0);
        fifoFull  = (count == CNT_W'(DEPTH));
        doPush    = lu_valid && !fifoFull;
        // A pipeline write to r0 is dropped, so it leaves the slot free for a pop.
        doPop     = !pipeWrite && !fifoEmpty;
        // A same-cycle pipeline write to the same register is younger, so the
        // incoming long-unit result is dead on arrival.
        pushLive  = (lu_waddr != 5'd0) && !(pipe_we && (pipe_waddr == lu_waddr));
    end

    assign lu_ready = !fifoFull;

    // Occupancy of each physical slot, measured as distance from the head
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slotOffset[i] = PTR_W'(i) - rdPtr;
            slotUsed[i]   = ({1'b0, slotOffset[i]} < count);
        end
    end

    // Hazard probe: any occupied, live entry targeting the queried register
    always_comb begin
        busyAny = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotUsed[i] && fifoLive[i] && (fifoAddr[i] == query_addr)) begin
                busyAny = 1'b1;
            end
        end
        query_busy = busyAny && (query_addr != 5'd0);
    end

    // Starvation counter next value: saturating count of non-pop cycles while non-empty
    always_comb begin
        starveNext = starveCnt;
        if (fifoEmpty || doPop) begin
            starveNext = '0;
        end else if (starveCnt != SCNT_W'(STARVE_MAX)) begin
            starveNext = starveCnt + SCNT_W'(1);
        end
    end

    // FIFO payload write on enqueue
    // NOTE: payload storage has no reset; the occupancy count decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoAddr[wrPtr] <= lu_waddr;
            fifoData[wrPtr] <= lu_wdata;
        end
    end

    // Live flags: cleared by younger pipeline writes, set on enqueue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifoLive[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipeWrite && (fifoAddr[i] == pipe_waddr)) begin
                    fifoLive[i] <= 1'b0;
                end
            end
            // The push slot is never occupied, so a kill above on it is irrelevant.
            if (doPush) begin
                fifoLive[wrPtr] <= pushLive;
            end
        end
    end

    // Pointers, occupancy, starvation state and stall request
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            starveCnt  <= '0;
            pipe_stall <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            starveCnt  <= starveNext;
            pipe_stall <= (starveNext == SCNT_W'(STARVE_MAX));
        end
    end

    // Register-file write port: pipeline first, then a live FIFO head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (pipeWrite) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_waddr;
            rf_wdata <= pipe_wdata;
        end else if (doPop && fifoLive[rdPtr]) begin
            rf_we    <= 1'b1;
            rf_waddr <= fifoAddr[rdPtr];
            rf_wdata <= fifoData[rdPtr];
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (DEPTH=2, STARVE_MAX=8).
// Inputs change 1 ns after a rising edge; outputs are checked there too.

module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic [4:0]  query_addr;
    logic        query_busy;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int passCnt = 0;
    int totalCnt = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .query_addr (query_addr),
        .query_busy (query_busy),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [4:0] addr);
        query_addr = addr;
        #1;
    endtask

    task automatic idle();
        pipe_we    = 1'b0;
        pipe_waddr = 5'd0;
        pipe_wdata = 32'd0;
        lu_valid   = 1'b0;
        lu_waddr   = 5'd0;
        lu_wdata   = 32'd0;
    endtask

    task automatic pipeW(input logic [4:0] a, input logic [31:0] d);
        pipe_we    = 1'b1;
        pipe_waddr = a;
        pipe_wdata = d;
    endtask

    task automatic luW(input logic [4:0] a, input logic [31:0] d);
        lu_valid = 1'b1;
        lu_waddr = a;
        lu_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        query_addr = 5'd0;

        // Reset state
        #12;
        check("reset rf_we", 32'(rf_we), 32'd0);
        check("reset rf_waddr", 32'(rf_waddr), 32'd0);
        check("reset rf_wdata", rf_wdata, 32'd0);
        check("reset pipe_stall", 32'(pipe_stall), 32'd0);
        check("reset lu_ready", 32'(lu_ready), 32'd1);
        probe(5'd7);
        check("reset query_busy", 32'(query_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Pipeline only: 1-cycle latency, r0 dropped
        pipeW(5'd5, 32'h1234);
        tick();
        check("pipe rf_we", 32'(rf_we), 32'd1);
        check("pipe rf_waddr", 32'(rf_waddr), 32'd5);
        check("pipe rf_wdata", rf_wdata, 32'h1234);
        pipeW(5'd0, 32'h55);
        tick();
        check("pipe r0 rf_we", 32'(rf_we), 32'd0);
        idle();

        // Long-unit drain: written 2 edges after transfer cycle begins
        luW(5'd7, 32'hAAAA);
        tick();
        idle();
        check("lu lat1 rf_we", 32'(rf_we), 32'd0);
        probe(5'd7);
        check("lu queued busy r7", 32'(query_busy), 32'd1);
        tick();
        check("lu lat2 rf_we", 32'(rf_we), 32'd1);
        check("lu lat2 rf_waddr", 32'(rf_waddr), 32'd7);
        check("lu lat2 rf_wdata", rf_wdata, 32'hAAAA);
        check("lu drained busy r7", 32'(query_busy), 32'd0);

        // Priority and full: pipeline writes every cycle, 3 results offered
        pipeW(5'd10, 32'h100);
        luW(5'd20, 32'h2000);
        tick();
        check("prio rf_waddr c1", 32'(rf_waddr), 32'd10);
        check("prio lu_ready c1", 32'(lu_ready), 32'd1);
        pipeW(5'd11, 32'h110);
        luW(5'd21, 32'h2100);
        tick();
        check("prio rf_waddr c2", 32'(rf_waddr), 32'd11);
        check("prio lu_ready full", 32'(lu_ready), 32'd0);
        pipeW(5'd12, 32'h120);
        luW(5'd22, 32'h2200);
        tick();
        check("prio rf_wdata c3", rf_wdata, 32'h120);
        check("prio lu_ready still full", 32'(lu_ready), 32'd0);
        probe(5'd20);
        check("prio busy r20", 32'(query_busy), 32'd1);
        probe(5'd21);
        check("prio busy r21", 32'(query_busy), 32'd1);
        probe(5'd22);
        check("prio busy r22 rejected", 32'(query_busy), 32'd0);
        idle();
        tick();
        check("drain1 rf_we", 32'(rf_we), 32'd1);
        check("drain1 rf_waddr", 32'(rf_waddr), 32'd20);
        check("drain1 rf_wdata", rf_wdata, 32'h2000);
        tick();
        check("drain2 rf_we", 32'(rf_we), 32'd1);
        check("drain2 rf_waddr", 32'(rf_waddr), 32'd21);
        check("drain2 rf_wdata", rf_wdata, 32'h2100);
        tick();
        check("drain empty rf_we", 32'(rf_we), 32'd0);

        // WAW cancel: queued r9 killed by younger pipeline write
        luW(5'd9, 32'h1);
        tick();
        idle();
        pipeW(5'd9, 32'h2);
        probe(5'd9);
        check("waw busy before kill", 32'(query_busy), 32'd1);
        tick();
        idle();
        check("waw pipe rf_waddr", 32'(rf_waddr), 32'd9);
        check("waw pipe rf_wdata", rf_wdata, 32'h2);
        check("waw busy after kill", 32'(query_busy), 32'd0);
        tick();
        check("waw dead pop rf_we", 32'(rf_we), 32'd0);
        check("waw lu_ready", 32'(lu_ready), 32'd1);

        // Same-cycle WAW: lu r3 and pipe r3 together
        luW(5'd3, 32'h33);
        pipeW(5'd3, 32'h44);
        tick();
        idle();
        check("waw2 rf_wdata", rf_wdata, 32'h44);
        probe(5'd3);
        check("waw2 busy r3", 32'(query_busy), 32'd0);
        tick();
        check("waw2 dead pop rf_we", 32'(rf_we), 32'd0);

        // Starvation: one entry queued, pipeline writes continuously
        luW(5'd15, 32'hF);
        pipeW(5'd1, 32'h0);
        tick();
        lu_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            pipeW(5'd1, 32'(i));
            tick();
        end
        check("starve 7 cycles stall", 32'(pipe_stall), 32'd0);
        pipeW(5'd2, 32'h8);
        tick();
        check("starve 8 cycles stall", 32'(pipe_stall), 32'd1);
        check("starve pipe not blocked", 32'(rf_waddr), 32'd2);
        pipeW(5'd1, 32'h9);
        tick();
        check("starve saturated stall", 32'(pipe_stall), 32'd1);
        idle();
        tick();
        check("starve pop rf_waddr", 32'(rf_waddr), 32'd15);
        check("starve pop rf_wdata", rf_wdata, 32'hF);
        check("starve cleared stall", 32'(pipe_stall), 32'd0);

        // Reset mid-operation with two entries queued
        pipeW(5'd1, 32'hA);
        luW(5'd16, 32'h16);
        tick();
        luW(5'd17, 32'h17);
        tick();
        check("pre-reset lu_ready", 32'(lu_ready), 32'd0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("async reset rf_we", 32'(rf_we), 32'd0);
        check("async reset lu_ready", 32'(lu_ready), 32'd1);
        probe(5'd16);
        check("async reset busy r16", 32'(query_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post-reset rf_we 1", 32'(rf_we), 32'd0);
        tick();
        check("post-reset rf_we 2", 32'(rf_we), 32'd0);
        tick();
        check("post-reset rf_we 3", 32'(rf_we), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
